// File: rtl/seg_pkg.sv
// Shared constants and types for the two-digit multiplexed seven-segment display driver.
package seg_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned DIGITS   = 2;
  localparam int unsigned BCD_W    = 4;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  localparam logic DIG_LOW  = 1'b0;
  localparam logic DIG_HIGH = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    BLINK_ON  = 2'b01,
    BLINK_OFF = 2'b10
  } blink_state_e;

  // Per-frame snapshot of the displayed value
  typedef struct packed {
    logic [BCD_W-1:0] digit_h;
    logic [BCD_W-1:0] digit_l;
    logic             blank_lz;
  } snap_t;

  // Active-high one-hot digit enable for the given digit index
  function automatic logic [DIGITS-1:0] dig_onehot(input logic idx);
    return (idx == DIG_HIGH) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/seg_display_driver_bcd_to_seg7.sv
// Combinational BCD to seven-segment decode (active-high), dash for non-BCD codes.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    if (blank) begin
      seg_c = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_driver.sv
// Two-digit multiplexed seven-segment driver: scan, per-frame snapshot, leading-zero
// blanking and alarm blink, with polarity applied at the output register.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLINK_DIV  = 25,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clock_1,
  input  logic              reset,
  input  logic [BCD_W-1:0]  time_h,
  input  logic [BCD_W-1:0]  time_l,
  input  logic              alarm,
  input  logic              blank_lz,
  output logic [SEG_W-1:0]  seg,
  output logic [DIGITS-1:0] dig_sel,
  output logic              frame_tick
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] FCNT_LAST = BW'(BLINK_DIV - 1);
  localparam logic [SEG_W-1:0]  SEG_INV = {SEG_W{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_INV = {DIGITS{ACTIVE_LOW}};

  logic [SW-1:0]    scan_cnt;
  logic             dig_idx;
  logic             scan_wrap_c;
  logic             frame_bnd_c;
  snap_t            snap;
  blink_state_e     state_q, state_d;
  logic [BW-1:0]    fcnt_q, fcnt_d;
  logic [BCD_W-1:0] cur_digit_c;
  logic             cur_blank_c;
  logic [SEG_W-1:0] seg_ah_c;

  assign scan_wrap_c = (scan_cnt == SCAN_LAST);
  assign frame_bnd_c = scan_wrap_c && (dig_idx == DIG_HIGH);

  // Slot timer and digit index
  always_ff @(posedge clock_1 or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      dig_idx  <= DIG_LOW;
    end else begin
      scan_cnt <= scan_wrap_c ? '0 : scan_cnt + SW'(1);
      if (scan_wrap_c) begin
        dig_idx <= ~dig_idx;
      end
    end
  end

  // Value snapshot, refreshed only at frame boundaries
  always_ff @(posedge clock_1 or negedge reset) begin
    if (!reset) begin
      snap <= '0;
    end else if (frame_bnd_c) begin
      snap.digit_h  <= time_h;
      snap.digit_l  <= time_l;
      snap.blank_lz <= blank_lz;
    end
  end

  // Blink FSM state register
  always_ff @(posedge clock_1 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Blink FSM next state; alarm is taken at the boundary, dropping it wins over the toggle
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (frame_bnd_c) begin
      case (state_q)
        IDLE: begin
          if (alarm) begin
            state_d = BLINK_ON;
            fcnt_d  = '0;
          end
        end
        BLINK_ON, BLINK_OFF: begin
          if (!alarm) begin
            state_d = IDLE;
            fcnt_d  = '0;
          end else if (fcnt_q == FCNT_LAST) begin
            fcnt_d  = '0;
            state_d = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
          end else begin
            fcnt_d  = fcnt_q + BW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  assign cur_digit_c = (dig_idx == DIG_HIGH) ? snap.digit_h : snap.digit_l;
  assign cur_blank_c = (state_q == BLINK_OFF) ||
                       ((dig_idx == DIG_HIGH) && snap.blank_lz && (snap.digit_h == 4'd0));

  bcd_to_seg7 u_dec (
    .bcd   (cur_digit_c),
    .blank (cur_blank_c),
    .seg_c (seg_ah_c)
  );

  // Output register with polarity applied
  always_ff @(posedge clock_1 or negedge reset) begin
    if (!reset) begin
      seg        <= SEG_INV;
      dig_sel    <= DIG_INV;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_ah_c ^ SEG_INV;
      dig_sel    <= dig_onehot(dig_idx) ^ DIG_INV;
      frame_tick <= frame_bnd_c;
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver: active-low and active-high instances share stimulus.
module tb_seg_display_driver;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLINK_DIV = 2;

  logic       clock_1 = 1'b0;
  logic       reset   = 1'b0;
  logic [3:0] time_h  = 4'h0;
  logic [3:0] time_l  = 4'h0;
  logic       alarm   = 1'b0;
  logic       blank_lz = 1'b0;
  logic [6:0] seg, seg_ah;
  logic [1:0] dig_sel, dig_sel_ah;
  logic       frame_tick, frame_tick_ah;

  int total = 0;
  int bad   = 0;

  always #5 clock_1 = ~clock_1;

  seg_display_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(1'b1)) dut (
    .clock_1(clock_1), .reset(reset), .time_h(time_h), .time_l(time_l), .alarm(alarm),
    .blank_lz(blank_lz), .seg(seg), .dig_sel(dig_sel), .frame_tick(frame_tick)
  );

  seg_display_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(1'b0)) dut_ah (
    .clock_1(clock_1), .reset(reset), .time_h(time_h), .time_l(time_l), .alarm(alarm),
    .blank_lz(blank_lz), .seg(seg_ah), .dig_sel(dig_sel_ah), .frame_tick(frame_tick_ah)
  );

  typedef struct {
    logic [3:0] h;
    logic [3:0] l;
    logic       blz;
    logic [6:0] exp_lo;
    logic [6:0] exp_hi;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // s/d are the active-low expectations; the active-high instance must show their complement
  task automatic chk_out(input string name, input logic [6:0] s, input logic [1:0] d);
    chk({name, ".seg"},    {1'b0, seg},        {1'b0, s});
    chk({name, ".dig"},    {6'b0, dig_sel},    {6'b0, d});
    chk({name, ".seg_ah"}, {1'b0, seg_ah},     {1'b0, ~s});
    chk({name, ".dig_ah"}, {6'b0, dig_sel_ah}, {6'b0, ~d});
  endtask

  task automatic chk_tick(input string name, input logic t);
    chk({name, ".tick"},    {7'b0, frame_tick},    {7'b0, t});
    chk({name, ".tick_ah"}, {7'b0, frame_tick_ah}, {7'b0, t});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock_1);
  endtask

  // Returns on the negedge where frame_tick is high, at least one cycle from now
  task automatic wait_tick();
    int n = 0;
    @(negedge clock_1);
    while (frame_tick !== 1'b1 && n < 40) begin
      @(negedge clock_1);
      n++;
    end
    chk("frame_tick_seen", {7'b0, frame_tick}, 8'h01);
  endtask

  initial begin
    vecs[0] = '{4'h1, 4'h5, 1'b0, 7'h12, 7'h79};
    vecs[1] = '{4'h0, 4'h7, 1'b1, 7'h78, 7'h7F};
    vecs[2] = '{4'h0, 4'h7, 1'b0, 7'h78, 7'h40};
    vecs[3] = '{4'h2, 4'hC, 1'b0, 7'h3F, 7'h24};
    vecs[4] = '{4'h9, 4'h8, 1'b1, 7'h00, 7'h10};
    vecs[5] = '{4'hF, 4'h0, 1'b1, 7'h40, 7'h3F};
    vecs[6] = '{4'h3, 4'h6, 1'b0, 7'h02, 7'h30};
    vecs[7] = '{4'h0, 4'h0, 1'b1, 7'h40, 7'h7F};

    // Reset state and first frame from the zero snapshot
    step(2);
    chk_out("reset", 7'h7F, 2'b11);
    chk_tick("reset", 1'b0);
    reset = 1'b1;
    step(1);
    chk_out("post_rst_lo", 7'h40, 2'b10);
    step(4);
    chk_out("post_rst_hi", 7'h40, 2'b01);
    step(3);
    chk_tick("post_rst_bnd", 1'b1);

    // Table: one full frame per vector, plus frame_tick spacing
    for (int v = 0; v < 8; v++) begin
      time_h   = vecs[v].h;
      time_l   = vecs[v].l;
      blank_lz = vecs[v].blz;
      wait_tick();
      for (int c = 0; c < 8; c++) begin
        step(1);
        if (c < 4) chk_out($sformatf("vec%0d.lo%0d", v, c), vecs[v].exp_lo, 2'b10);
        else       chk_out($sformatf("vec%0d.hi%0d", v, c), vecs[v].exp_hi, 2'b01);
        chk_tick($sformatf("vec%0d.c%0d", v, c), (c == 7));
      end
    end

    // Mid-frame input change stays invisible until after the next boundary
    time_h = 4'h1; time_l = 4'h5; blank_lz = 1'b0; alarm = 1'b0;
    wait_tick();
    step(2);
    chk_out("mid.lo_before", 7'h12, 2'b10);
    time_l = 4'h8;
    step(1);
    chk_out("mid.lo_held", 7'h12, 2'b10);
    step(4);
    chk_out("mid.hi_held", 7'h79, 2'b01);
    step(1);
    chk_out("mid.bnd", 7'h79, 2'b01);
    chk_tick("mid.bnd", 1'b1);
    step(1);
    chk_out("mid.new_lo", 7'h00, 2'b10);

    // Alarm blink: 2 frames on, 2 off, 2 on
    time_h = 4'h0; time_l = 4'h0; alarm = 1'b1;
    wait_tick();
    for (int f = 0; f < 6; f++) begin
      step(1);
      chk_out($sformatf("blink.f%0d", f), (f == 2 || f == 3) ? 7'h7F : 7'h40, 2'b10);
      step(7);
    end
    step(3);
    chk_out("blink.off_lo", 7'h7F, 2'b10);
    alarm = 1'b0;
    step(4);
    chk_out("blink.off_hi", 7'h7F, 2'b01);
    step(2);
    chk_out("blink.drop", 7'h40, 2'b10);

    // Reset asserted in the middle of a BLINK_OFF frame
    time_h = 4'h1; time_l = 4'h5; alarm = 1'b1;
    wait_tick();
    step(16);
    step(3);
    chk_out("rst.blink_off", 7'h7F, 2'b10);
    reset = 1'b0;
    #1;
    chk_out("rst.async", 7'h7F, 2'b11);
    chk_tick("rst.async", 1'b0);
    step(2);
    reset = 1'b1;
    step(1);
    chk_out("rst.rel_lo", 7'h40, 2'b10);
    step(4);
    chk_out("rst.rel_hi", 7'h40, 2'b01);
    step(3);
    chk_tick("rst.rel_bnd", 1'b1);
    step(1);
    chk_out("rst.first_frame", 7'h12, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
